// File: rtl/mdu_pkg.sv
// Shared constants for the iterative RV32M multiply/divide unit.
package mdu_pkg;

   localparam int unsigned MDU_WIDTH = 32;

   // M-extension funct3 encodings
   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   // Control states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIN  = 2'd2,
      DONE = 2'd3
   } state_e;

   // Most-negative XLEN value, used for signed-overflow detection
   localparam logic [MDU_WIDTH-1:0] MOST_NEG = {1'b1, {(MDU_WIDTH-1){1'b0}}};

endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply/divide: shift-add multiply and restoring divide on one
// shared 2*WIDTH accumulator and adder, with a sign fix-up cycle before done.
module mdu_iter
   import mdu_pkg::*;
#(
   parameter int unsigned WIDTH = MDU_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       funct3,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int unsigned CW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MOST_NEG_W = (WIDTH == MDU_WIDTH) ? WIDTH'(MOST_NEG)
                                                                  : {1'b1, {(WIDTH-1){1'b0}}};

   state_e             state_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [WIDTH-1:0]   mcand_q;
   logic [CW-1:0]      cnt_q;
   logic [2:0]         op_q;
   logic               neg_q;
   logic               negr_q;
   logic               spec_q;
   logic               busy_q;
   logic               done_q;
   logic [WIDTH-1:0]   result_q;

   logic               sa, sb, div_op, div0, ovf;
   logic [WIDTH-1:0]   a_mag, b_mag, spec_val;
   logic               mul_mode;
   logic [WIDTH:0]     rem_sh, add_a, add_b;
   logic [WIDTH+1:0]   sum;
   logic [2*WIDTH-1:0] acc_d;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quot_fix, rem_fix, result_d;

   // Operand decode at acceptance: sign flags, magnitudes and shortcut cases
   always_comb begin
      div_op   = funct3[2];
      sa       = a[WIDTH-1] & ((funct3 == OP_MULH) | (funct3 == OP_MULHSU) |
                               (funct3 == OP_DIV)  | (funct3 == OP_REM));
      sb       = b[WIDTH-1] & ((funct3 == OP_MULH) | (funct3 == OP_DIV) |
                               (funct3 == OP_REM));
      a_mag    = sa ? -a : a;
      b_mag    = sb ? -b : b;
      div0     = div_op & (b == '0);
      ovf      = ((funct3 == OP_DIV) | (funct3 == OP_REM)) &
                 (a == MOST_NEG_W) & (b == '1);
      spec_val = '0;
      if (div0)     spec_val = funct3[1] ? a : '1;
      else if (ovf) spec_val = funct3[1] ? '0 : a;
   end

   // One iteration step; the adder adds for multiply and trial-subtracts for divide
   always_comb begin
      mul_mode = ~op_q[2];
      rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
      add_a    = mul_mode ? {1'b0, acc_q[2*WIDTH-1:WIDTH]} : rem_sh;
      add_b    = mul_mode ? {1'b0, (acc_q[0] ? mcand_q : '0)} : ~{1'b0, mcand_q};
      sum      = {1'b0, add_a} + {1'b0, add_b} + {{(WIDTH+1){1'b0}}, ~mul_mode};
      if (mul_mode)
         acc_d = {sum[WIDTH:0], acc_q[WIDTH-1:1]};
      else if (sum[WIDTH+1])
         acc_d = {sum[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else
         acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
   end

   // Sign fix-up and result select for the FIN cycle
   always_comb begin
      prod_fix = neg_q  ? -acc_q : acc_q;
      quot_fix = neg_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      rem_fix  = negr_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
      case (op_q)
         OP_MUL:                        result_d = prod_fix[WIDTH-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU:  result_d = prod_fix[2*WIDTH-1:WIDTH];
         OP_DIV, OP_DIVU:               result_d = quot_fix;
         default:                       result_d = rem_fix;
      endcase
      if (spec_q) result_d = acc_q[WIDTH-1:0];
   end

   // Control FSM and datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         acc_q    <= '0;
         mcand_q  <= '0;
         cnt_q    <= '0;
         op_q     <= '0;
         neg_q    <= 1'b0;
         negr_q   <= 1'b0;
         spec_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else if (flush) begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               done_q <= 1'b0;
               if (start) begin
                  op_q    <= funct3;
                  neg_q   <= sa ^ sb;
                  negr_q  <= sa;
                  spec_q  <= div0 | ovf;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  mcand_q <= div_op ? b_mag : a_mag;
                  if (div0 | ovf) begin
                     acc_q   <= {{WIDTH{1'b0}}, spec_val};
                     state_q <= FIN;
                  end else begin
                     acc_q   <= {{WIDTH{1'b0}}, (div_op ? a_mag : b_mag)};
                     state_q <= CALC;
                  end
               end else begin
                  state_q <= IDLE;
               end
            end
            CALC: begin
               acc_q <= acc_d;
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == CW'(WIDTH-1)) state_q <= FIN;
            end
            FIN: begin
               result_q <= result_d;
               busy_q   <= 1'b0;
               done_q   <= 1'b1;
               state_q  <= DONE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: random and directed ops against an
// arithmetic reference model, with latency, flush, reset and hold checks.
module tb_mdu_iter;
   import mdu_pkg::*;

   localparam int unsigned W = 32;
   localparam logic [W-1:0] MN = 32'h8000_0000;

   logic         clk = 1'b0;
   logic         reset, start, flush;
   logic [2:0]   funct3;
   logic [W-1:0] a, b;
   logic         busy, done;
   logic [W-1:0] result;

   always #5 clk = ~clk;

   mdu_iter #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .funct3(funct3),
      .a(a), .b(b), .flush(flush), .busy(busy), .done(done), .result(result)
   );

   typedef struct {
      logic [31:0] res;
      int          acc;
      int          lat;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   chk_cnt = 0;
   int   pass_cnt = 0;
   int   done_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Reference model straight from the RV32M definitions
   function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] x,
                                             input logic [31:0] y);
      longint      sx = longint'($signed(x));
      longint      sy = longint'($signed(y));
      longint      uy = longint'({32'b0, y});
      logic [63:0] p;
      case (f)
         OP_MUL:    begin p = {32'b0, x} * {32'b0, y}; return p[31:0];  end
         OP_MULH:   begin p = 64'(sx * sy);            return p[63:32]; end
         OP_MULHSU: begin p = 64'(sx * uy);            return p[63:32]; end
         OP_MULHU:  begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
         OP_DIV: begin
            if (y == 0) return 32'hFFFF_FFFF;
            if (x == MN && y == 32'hFFFF_FFFF) return x;
            return 32'($signed(x) / $signed(y));
         end
         OP_DIVU: begin
            if (y == 0) return 32'hFFFF_FFFF;
            return x / y;
         end
         OP_REM: begin
            if (y == 0) return x;
            if (x == MN && y == 32'hFFFF_FFFF) return 32'h0;
            return 32'($signed(x) % $signed(y));
         end
         default: begin
            if (y == 0) return x;
            return x % y;
         end
      endcase
   endfunction

   function automatic int exp_lat(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
      if (f[2] && (y == 0 || ((f == OP_DIV || f == OP_REM) && x == MN && y == 32'hFFFF_FFFF)))
         return 2;
      return 34;
   endfunction

   // Monitor: pop expected entry on every done pulse
   always @(negedge clk) begin : mon
      exp_t e;
      if (!reset && done) begin
         done_cnt++;
         if (sb.size() == 0) begin
            chk_cnt++;
            $display("FAIL unexpected_done: result %h with nothing pending", result);
         end else begin
            e = sb.pop_front();
            check({e.name, "_result"}, result, e.res);
            check({e.name, "_latency"}, 32'(cyc - e.acc + 1), 32'(e.lat));
         end
      end
   end

   task automatic wait_idle();
      for (int i = 0; i < 100 && busy; i++) @(negedge clk);
      check("idle_wait", 32'(busy), 32'd0);
   endtask

   // Called at a negedge with the unit not busy; returns at the negedge after acceptance
   task automatic launch(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                         input string nm, input bit push);
      start = 1'b1; funct3 = f; a = x; b = y;
      @(negedge clk);
      start = 1'b0;
      if (push) sb.push_back('{ref_model(f, x, y), cyc, exp_lat(f, x, y), nm});
   endtask

   task automatic drain(input string nm);
      for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         chk_cnt++;
         $display("FAIL %s_timeout: %0d results still pending, required 0", nm, sb.size());
         sb.delete();
      end
   endtask

   task automatic run_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                         input string nm);
      wait_idle();
      launch(f, x, y, nm, 1'b1);
      drain(nm);
   endtask

   initial begin : wdog
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int dc0;
      logic [2:0]  rf;
      logic [31:0] rx, ry;
      reset = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; a = '0; b = '0;
      repeat (3) @(negedge clk);
      check("reset_busy",   32'(busy), 32'd0);
      check("reset_done",   32'(done), 32'd0);
      check("reset_result", result,    32'd0);
      reset = 1'b0;
      @(negedge clk);

      // Reset in the middle of CALC clears the held result
      run_op(OP_MUL, 32'd3, 32'd5, "mul_3x5");
      launch(OP_MUL, 32'd123, 32'd456, "pre_reset", 1'b0);
      repeat (5) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("rst_mid_busy",   32'(busy), 32'd0);
      check("rst_mid_done",   32'(done), 32'd0);
      check("rst_mid_result", result,    32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      run_op(OP_MUL, 32'd7, 32'd6, "mul_7x6");

      // Directed arithmetic cases
      run_op(OP_MULH,   32'hFFFF_FFFF, 32'd2, "mulh_m1x2");
      run_op(OP_MULHU,  32'hFFFF_FFFF, 32'd2, "mulhu_m1x2");
      run_op(OP_MULHSU, 32'hFFFF_FFFF, 32'd2, "mulhsu_m1x2");
      run_op(OP_MUL,    32'hFFFF_FFFF, 32'd2, "mul_m1x2");
      run_op(OP_DIV,    32'hFFFF_FFF9, 32'd2, "div_m7_2");
      run_op(OP_REM,    32'hFFFF_FFF9, 32'd2, "rem_m7_2");
      run_op(OP_DIVU,   32'd100, 32'd7, "divu_100_7");
      run_op(OP_REMU,   32'd100, 32'd7, "remu_100_7");
      run_op(OP_DIVU,   32'h1234_5678, 32'd0, "divu_by0");
      run_op(OP_REMU,   32'h1234_5678, 32'd0, "remu_by0");
      run_op(OP_DIV,    32'h1234_5678, 32'd0, "div_by0");
      run_op(OP_DIV,    MN, 32'hFFFF_FFFF, "div_ovf");
      run_op(OP_REM,    MN, 32'hFFFF_FFFF, "rem_ovf");
      run_op(OP_MUL,    32'h1234_5678, 32'd0, "mul_by0");

      // start while busy is ignored
      wait_idle();
      launch(OP_MUL, 32'd7, 32'd6, "mul_ignored_start", 1'b1);
      repeat (4) @(negedge clk);
      start = 1'b1; funct3 = OP_DIVU; a = 32'd999; b = 32'd3;
      @(negedge clk);
      start = 1'b0;
      drain("mul_ignored_start");

      // Back-to-back: new start in the DONE cycle, old result held until FIN
      wait_idle();
      launch(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "b2b_first", 1'b1);
      for (int i = 0; i < 100 && !done; i++) @(negedge clk);
      check("b2b_done_seen", 32'(done), 32'd1);
      launch(OP_DIVU, 32'd1000, 32'd9, "b2b_second", 1'b1);
      check("b2b_busy",   32'(busy), 32'd1);
      check("b2b_hold_0", result, 32'hFFFF_FFFE);
      repeat (15) @(negedge clk);
      check("b2b_hold_15", result, 32'hFFFF_FFFE);
      repeat (17) @(negedge clk);
      check("b2b_hold_32", result, 32'hFFFF_FFFE);
      drain("b2b_second");

      // Flush at cycle 10 of a divide: no done, result kept
      wait_idle();
      dc0 = done_cnt;
      launch(OP_DIV, 32'd1000, 32'd7, "flushed_div", 1'b0);
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_busy",   32'(busy), 32'd0);
      check("flush_done",   32'(done), 32'd0);
      check("flush_result", result,    32'd111);
      repeat (40) @(negedge clk);
      check("flush_no_done",   32'(done_cnt - dc0), 32'd0);
      check("flush_result_40", result, 32'd111);

      // Flush together with start drops the start
      dc0 = done_cnt;
      flush = 1'b1; start = 1'b1; funct3 = OP_MUL; a = 32'd2; b = 32'd2;
      @(negedge clk);
      flush = 1'b0; start = 1'b0;
      check("flush_start_busy", 32'(busy), 32'd0);
      repeat (40) @(negedge clk);
      check("flush_start_no_done", 32'(done_cnt - dc0), 32'd0);

      // Randomised operations with corner-biased operands
      for (int n = 0; n < 40; n++) begin
         rf = 3'($urandom_range(0, 7));
         rx = $urandom;
         ry = $urandom;
         case ($urandom_range(0, 7))
            0: ry = 32'd0;
            1: ry = 32'hFFFF_FFFF;
            2: rx = MN;
            3: begin rx = MN; ry = 32'hFFFF_FFFF; end
            4: begin rx = 32'($urandom_range(0, 50)); ry = 32'($urandom_range(1, 9)); end
            default: ;
         endcase
         run_op(rf, rx, ry, $sformatf("rnd%0d_f%0d", n, rf));
      end

      wait_idle();
      repeat (3) @(negedge clk);
      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
